ppu_mem_arbiter: RTL and testbench
==================================

PPU_MEM_ARBITER -- requirements
Module: ppu_mem_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, host write FIFO entries (power of 2, 2..32).
REQ-002 SHALL have parameter STARVE_LIMIT, default 64, consecutive denied cycles before forced host slot.
REQ-003 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: chipselect  in  1, write  in  1, address  in  14, writedata  in  32; host write bus.
REQ-005 SHALL have port: waitrequest  out  1  host stall, equals FIFO full.
REQ-006 SHALL have ports: vblank  in  1  frame blanking; ppu_req  in  1, ppu_sel  in  3, ppu_addr  in  11  PPU fetch request.
REQ-007 SHALL have ports: ppu_gnt  out  1; ppu_rvalid  out  1; ppu_rdata  out  32  fetch grant and return.
REQ-008 SHALL have ports: mem_sel  out  3, mem_addr  out  11, mem_we  out  1, mem_wdata  out  32, mem_rdata  in  32  shared RAM port.
REQ-009 SHALL have port: bad_sel_cnt  out  8  saturating count of dropped writes.

Function
REQ-010 SHALL decode host address[13:11] as region: 0 tile_buffer, 1 tile_graphics, 2 sprite_graphics, 3 color_palettes, 4 OAM; address[10:0] word address.
REQ-011 SHALL push {sel,addr,data} into FIFO when chipselect & write & !waitrequest and sel <= 4.
REQ-012 SHALL drop sel 5..7 writes without push, incrementing bad_sel_cnt, saturating at 255.
REQ-013 SHALL drive waitrequest combinationally high when FIFO holds FIFO_DEPTH entries.
REQ-014 SHALL arbitrate each cycle: vblank=1 -> host FIFO head first, PPU otherwise; vblank=0 -> PPU first, host only when ppu_req=0.
REQ-015 SHALL assert ppu_gnt combinationally in the cycle a PPU request wins.
REQ-016 SHALL register mem_* one cycle after grant: PPU -> mem_we=0, mem_sel/addr from request; host -> mem_we=1, FIFO head fields, pop.
REQ-017 SHALL assert ppu_rvalid two cycles after ppu_gnt, ppu_rdata = mem_rdata in that cycle (RAM read latency 1).
REQ-018 SHALL hold mem_we=0 and mem_sel/addr/wdata at last values on idle cycles.
REQ-019 SHALL use FSM states IDLE, PPU_RD, HOST_WR reflecting previous-cycle grant; any state -> any state per REQ-014.
REQ-020 SHALL accept push and pop in the same cycle when FIFO non-full and non-empty, count unchanged.
REQ-021 SHALL keep FIFO order strict; no write reordering or merging.
REQ-022 SHALL treat vblank edges as taking effect in the same cycle's arbitration.

Reset
REQ-023 SHALL on reset_n low, asynchronously: FIFO empty, waitrequest 0, mem_we 0, mem_sel/addr/wdata 0, ppu_gnt/ppu_rvalid 0, bad_sel_cnt 0, FSM IDLE, starve counter 0.
REQ-024 SHALL discard queued writes and in-flight reads when reset asserts mid-operation; no rvalid after release for pre-reset grants.

Configuration
REQ-025 SHALL compile starvation guard with PPU_ARB_STARVE_GUARD_EN: counter increments each cycle the FIFO is non-empty and host denied, clears on host grant; at STARVE_LIMIT host wins one cycle over PPU.
REQ-026 SHALL, without PPU_ARB_STARVE_GUARD_EN, follow REQ-014 strictly, and the counter SHALL not exist.

Structure
REQ-027 SHALL place region select enum (tile_buffer..OAM), FIFO entry struct {sel[2:0],addr[10:0],data[31:0]}, and RAM latency constant in shared package ppu_pkg.
REQ-028 SHALL implement FIFO as sub-module ppu_wr_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-029 SHALL test: vblank=1, host writes 4 OAM words addr 0..3 -> mem_we pulses in order, data matches, waitrequest stays 0.
REQ-030 SHALL test: vblank=0, ppu_req held, 9 host writes at FIFO_DEPTH=8 -> waitrequest high after 8th, no mem_we until ppu_req drops (guard off).
REQ-031 SHALL test: with PPU_ARB_STARVE_GUARD_EN, ppu_req held 200 cycles, FIFO non-empty -> one host write every 65 cycles, PPU denied exactly in those cycles.
REQ-032 SHALL test: PPU read sel=3 addr=2 granted cycle N -> ppu_rvalid cycle N+2 with mem_rdata 0x00AABBCC returned.
REQ-033 SHALL test: 300 writes to address[13:11]=6 -> no FIFO push, bad_sel_cnt saturates at 255.
REQ-034 SHALL test: reset_n low with 5 queued writes and a read in flight -> FIFO empty, no mem_we, no ppu_rvalid after release.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ppu_pkg                                                    |
// | Description : Shared types and constants for the PPU memory arbiter.     |
// |               - region_sel_e : host address[13:11] region decode         |
// |               - fifo_entry_t : one queued host write {sel, addr, data}   |
// |               - C_RAM_RD_LATENCY : shared RAM read latency (cycles)      |
// |               - is_valid_sel : true for regions that exist (0..4)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ppu_pkg;

  typedef enum logic [2:0] {
    SEL_TILE_BUFFER     = 3'd0,
    SEL_TILE_GRAPHICS   = 3'd1,
    SEL_SPRITE_GRAPHICS = 3'd2,
    SEL_COLOR_PALETTES  = 3'd3,
    SEL_OAM             = 3'd4
  } region_sel_e;

  typedef struct packed {
    logic [2:0]  sel;
    logic [10:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  // Cycles from mem_sel/mem_addr being presented to mem_rdata being valid.
  localparam int C_RAM_RD_LATENCY = 1;

  // Region codes 5..7 have no backing memory.
  function automatic logic is_valid_sel(input logic [2:0] sel);
    return (sel <= SEL_OAM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_wr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ppu_wr_fifo                                                |
// | Description : Synchronous FIFO holding queued host writes in strict      |
// |               arrival order. Push and pop in the same cycle are allowed  |
// |               when the FIFO is neither full nor empty.                   |
// | Ports       : clk, reset_n (async, active-low)                           |
// |               push, push_data   - enqueue one entry (ignored when full)  |
// |               pop, pop_data     - dequeue head (ignored when empty);     |
// |                                   pop_data always shows the head         |
// |               full, empty, count - occupancy status                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ppu_wr_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  output fifo_entry_t              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 C_PTR_W = $clog2(DEPTH);
  localparam logic [C_PTR_W:0]   C_FULL  = (C_PTR_W + 1)'(DEPTH);

  fifo_entry_t          r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_PTR_W:0]     r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == C_FULL);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ppu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ppu_mem_arbiter                                            |
// | Description : Shares one single-port video RAM between host writes       |
// |               (buffered in a FIFO) and PPU fetches. During vblank the    |
// |               host FIFO head has priority; during active display the PPU |
// |               has priority and the host only uses idle PPU cycles.       |
// |               The RAM port (mem_*) is registered one cycle after the     |
// |               grant; PPU read data returns two cycles after ppu_gnt.     |
// | Options     : PPU_ARB_STARVE_GUARD_EN - when defined, a host write that  |
// |               has waited STARVE_LIMIT cycles wins one slot over the PPU. |
// | Ports       : clk, reset_n (async, active-low)                           |
// |               chipselect, write, address[13:0], writedata[31:0],        |
// |               waitrequest               - host write bus                 |
// |               vblank                    - frame blanking indicator       |
// |               ppu_req, ppu_sel, ppu_addr, ppu_gnt, ppu_rvalid,           |
// |               ppu_rdata                 - PPU fetch request/return       |
// |               mem_sel, mem_addr, mem_we, mem_wdata, mem_rdata - RAM port |
// |               bad_sel_cnt               - saturating dropped-write count |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ppu_mem_arbiter
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  // host write bus
  input  logic        chipselect,
  input  logic        write,
  input  logic [13:0] address,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  // PPU side
  input  logic        vblank,
  input  logic        ppu_req,
  input  logic [2:0]  ppu_sel,
  input  logic [10:0] ppu_addr,
  output logic        ppu_gnt,
  output logic        ppu_rvalid,
  output logic [31:0] ppu_rdata,
  // shared RAM port
  output logic [2:0]  mem_sel,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic [7:0]  bad_sel_cnt
);

  localparam int C_CNT_W   = $clog2(FIFO_DEPTH) + 1;
  // One cycle to register the address, then the RAM read latency.
  localparam int C_RD_PIPE = 1 + C_RAM_RD_LATENCY;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 32) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_param_check
    $error("ppu_mem_arbiter: FIFO_DEPTH must be a power of 2 in 2..32, STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PPU_RD  = 2'd1,
    HOST_WR = 2'd2
  } arb_state_e;

  // --------------------------------------------------------------------------
  // Host write intake
  // --------------------------------------------------------------------------
  logic [2:0]          w_host_sel;
  logic                w_wr_strobe;
  logic                w_push;
  logic                w_bad_write;
  fifo_entry_t         w_push_entry;
  fifo_entry_t         w_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic [C_CNT_W-1:0]  w_unused_fifo_count;

  assign w_host_sel   = address[13:11];
  // A write is accepted only in a cycle where the host is not stalled.
  assign w_wr_strobe  = chipselect & write & ~w_fifo_full;
  assign w_push       = w_wr_strobe & is_valid_sel(w_host_sel);
  assign w_bad_write  = w_wr_strobe & ~is_valid_sel(w_host_sel);
  assign w_push_entry = {w_host_sel, address[10:0], writedata};
  assign waitrequest  = w_fifo_full;

  ppu_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_unused_fifo_count)
  );

  // --------------------------------------------------------------------------
  // Arbitration FSM. The state records which requester owned the RAM port in
  // the previous cycle; every cycle is arbitrated afresh so any state may
  // follow any other.
  // --------------------------------------------------------------------------
  arb_state_e  r_state;
  arb_state_e  w_next_state;
  logic        w_host_pending;
  logic        w_force_host;
  logic        w_host_win;
  logic        w_ppu_win;

  assign w_host_pending = ~w_fifo_empty;

  always_comb begin
    w_host_win   = 1'b0;
    w_ppu_win    = 1'b0;
    w_next_state = IDLE;
    // Gating on reset_n keeps ppu_gnt low while reset is asserted even
    // though the grant is combinational from ppu_req.
    if (reset_n) begin
      if (w_force_host) begin
        w_host_win = 1'b1;
      end else if (vblank) begin
        w_host_win = w_host_pending;
        w_ppu_win  = ppu_req & ~w_host_pending;
      end else begin
        w_ppu_win  = ppu_req;
        w_host_win = w_host_pending & ~ppu_req;
      end
    end
    if (w_ppu_win) begin
      w_next_state = PPU_RD;
    end else if (w_host_win) begin
      w_next_state = HOST_WR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  assign ppu_gnt = w_ppu_win;
  assign w_pop   = w_host_win;
  assign mem_we  = (r_state == HOST_WR);

  // --------------------------------------------------------------------------
  // Registered RAM port. Address/data hold their last values when idle so
  // the RAM sees no spurious toggling.
  // --------------------------------------------------------------------------
  logic [2:0]   r_mem_sel;
  logic [10:0]  r_mem_addr;
  logic [31:0]  r_mem_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_sel   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_ppu_win) begin
      r_mem_sel   <= ppu_sel;
      r_mem_addr  <= ppu_addr;
    end else if (w_host_win) begin
      r_mem_sel   <= w_head.sel;
      r_mem_addr  <= w_head.addr;
      r_mem_wdata <= w_head.data;
    end
  end

  assign mem_sel   = r_mem_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // --------------------------------------------------------------------------
  // Read return: a shift register tracks each PPU grant until its data is
  // on mem_rdata. Reset clears it, so no pre-reset grant ever returns.
  // --------------------------------------------------------------------------
  logic [C_RD_PIPE-1:0] r_rd_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_pipe <= '0;
    else          r_rd_pipe <= (r_rd_pipe << 1) | C_RD_PIPE'(w_ppu_win);
  end

  assign ppu_rvalid = r_rd_pipe[C_RD_PIPE-1];
  assign ppu_rdata  = mem_rdata;

  // --------------------------------------------------------------------------
  // Dropped-write counter (regions 5..7), saturating at 255.
  // --------------------------------------------------------------------------
  logic [7:0] r_bad_sel_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bad_sel_cnt <= '0;
    end else if (w_bad_write && (r_bad_sel_cnt != 8'hFF)) begin
      r_bad_sel_cnt <= r_bad_sel_cnt + 8'd1;
    end
  end

  assign bad_sel_cnt = r_bad_sel_cnt;

  // --------------------------------------------------------------------------
  // Starvation guard. The counter advances on every cycle a queued write is
  // passed over; on reaching STARVE_LIMIT the host takes the next slot.
  // --------------------------------------------------------------------------
`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam int                   C_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [C_STARVE_W-1:0] C_LIMIT   = C_STARVE_W'(STARVE_LIMIT);

  logic [C_STARVE_W-1:0] r_starve_cnt;

  assign w_force_host = w_host_pending && (r_starve_cnt >= C_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_host_win) begin
      r_starve_cnt <= '0;
    end else if (w_host_pending && (r_starve_cnt < C_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_host = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ppu_mem_arbiter                                         |
// | Description : Self-checking bench for ppu_mem_arbiter. A behavioural     |
// |               model (write queue, pending-read list, RAM image) predicts |
// |               every output each cycle; directed table vectors and short  |
// |               hand sequences cover the corner cases, then random traffic.|
// |               Define PPU_ARB_STARVE_GUARD_EN to exercise the guard.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ppu_mem_arbiter;

  localparam int FIFO_DEPTH   = 8;
  localparam int STARVE_LIMIT = 64;
`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, write;
  logic [13:0] address;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        vblank, ppu_req;
  logic [2:0]  ppu_sel;
  logic [10:0] ppu_addr;
  logic        ppu_gnt, ppu_rvalid;
  logic [31:0] ppu_rdata;
  logic [2:0]  mem_sel;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  bad_sel_cnt;

  ppu_mem_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .chipselect(chipselect), .write(write), .address(address), .writedata(writedata),
    .waitrequest(waitrequest),
    .vblank(vblank), .ppu_req(ppu_req), .ppu_sel(ppu_sel), .ppu_addr(ppu_addr),
    .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .bad_sel_cnt(bad_sel_cnt)
  );

  always #5 clk = ~clk;

  // Environment RAM: one-cycle read latency, read-before-write.
  bit [31:0] ram [0:7][0:2047];
  always @(posedge clk) begin
    if (mem_we) ram[mem_sel][mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_sel][mem_addr];
  end

  // ---------------- reference model state ----------------
  typedef struct { bit [2:0] sel; bit [10:0] addr; bit [31:0] data; } wr_t;
  typedef struct { int due; bit [31:0] data; } rd_t;
  wr_t       mq[$];
  rd_t       rq[$];
  bit [31:0] img [0:7][0:2047];
  int        cyc, starve, exp_bad;
  bit        exp_we;
  bit [2:0]  exp_sel;
  bit [10:0] exp_addr;
  bit [31:0] exp_wdata;

  int tests, fails;
  logic        s_wait, s_gnt, s_rv;
  logic [31:0] s_rdata;
  int          rv_count, wait_seen;
  logic [31:0] we_data_log[$];
  logic [10:0] we_addr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    we_data_log.delete(); we_addr_log.delete(); rv_count = 0; wait_seen = 0;
  endtask

  task automatic model_reset();
    mq.delete(); rq.delete();
    starve = 0; exp_bad = 0; exp_we = 0; exp_sel = 0; exp_addr = 0; exp_wdata = 0;
  endtask

  // One clock cycle: entered at a negedge with inputs already driven.
  task automatic step();
    bit exp_wait, acc, host_ready, host_g, ppu_g, exp_rv;
    wr_t e;
    rd_t r;
    #1;
    s_wait = waitrequest; s_gnt = ppu_gnt; s_rv = ppu_rvalid; s_rdata = ppu_rdata;
    if (mem_we) begin we_data_log.push_back(mem_wdata); we_addr_log.push_back(mem_addr); end
    if (ppu_rvalid) rv_count++;
    if (waitrequest) wait_seen++;

    exp_wait   = (mq.size() == FIFO_DEPTH);
    host_ready = (mq.size() != 0);
    if (GUARD && host_ready && starve >= STARVE_LIMIT) host_g = 1'b1;
    else if (vblank)                                   host_g = host_ready;
    else                                               host_g = host_ready && !ppu_req;
    ppu_g  = ppu_req && !host_g;
    exp_rv = (rq.size() != 0) && (rq[0].due == cyc);

    chk("waitrequest", 32'(waitrequest), 32'(exp_wait));
    chk("ppu_gnt",     32'(ppu_gnt),     32'(ppu_g));
    chk("mem_we",      32'(mem_we),      32'(exp_we));
    chk("mem_sel",     32'(mem_sel),     32'(exp_sel));
    chk("mem_addr",    32'(mem_addr),    32'(exp_addr));
    chk("mem_wdata",   mem_wdata,        exp_wdata);
    chk("ppu_rvalid",  32'(ppu_rvalid),  32'(exp_rv));
    chk("bad_sel_cnt", 32'(bad_sel_cnt), 32'(exp_bad));
    if (exp_rv) begin
      chk("ppu_rdata", ppu_rdata, rq[0].data);
      void'(rq.pop_front());
    end

    if (ppu_g) begin
      r.due = cyc + 2; r.data = img[ppu_sel][ppu_addr]; rq.push_back(r);
      exp_we = 0; exp_sel = ppu_sel; exp_addr = ppu_addr;
    end else if (host_g) begin
      e = mq.pop_front();
      exp_we = 1; exp_sel = e.sel; exp_addr = e.addr; exp_wdata = e.data;
      img[e.sel][e.addr] = e.data;
    end else begin
      exp_we = 0;
    end
    if (host_g) starve = 0;
    else if (host_ready) starve++;

    acc = chipselect && write && !exp_wait;
    if (acc) begin
      if (address[13:11] <= 3'd4) begin
        e.sel = address[13:11]; e.addr = address[10:0]; e.data = writedata;
        mq.push_back(e);
      end else if (exp_bad < 255) begin
        exp_bad++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    chipselect = 0; write = 0; address = '0; writedata = '0;
    vblank = 0; ppu_req = 0; ppu_sel = '0; ppu_addr = '0;
  endtask

  task automatic host_wr(input logic [13:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
  endtask

  // Asserts reset mid-cycle (inputs left as the caller drove them).
  task automatic apply_reset();
    reset_n = 0;
    #1;
    chk("rst waitrequest", 32'(waitrequest), 32'd0);
    chk("rst mem_we",      32'(mem_we),      32'd0);
    chk("rst mem_sel",     32'(mem_sel),     32'd0);
    chk("rst mem_addr",    32'(mem_addr),    32'd0);
    chk("rst mem_wdata",   mem_wdata,        32'd0);
    chk("rst ppu_gnt",     32'(ppu_gnt),     32'd0);
    chk("rst ppu_rvalid",  32'(ppu_rvalid),  32'd0);
    chk("rst bad_sel_cnt", 32'(bad_sel_cnt), 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    idle_inputs();
    reset_n = 1;
  endtask

  typedef struct {
    bit cs, wr; bit [13:0] adr; bit [31:0] wd;
    bit vb, pr; bit [2:0] ps; bit [10:0] pa;
    bit e_wait, e_gnt;
  } vec_t;
  vec_t vt[10];

  int acc_n, n_gnt0;
  int denied[$];
  logic [2:0] rs;

  initial begin
    tests = 0; fails = 0; cyc = 0;
    reset_n = 0; idle_inputs(); model_reset(); clear_logs();

    vt[0] = '{0,0,14'h0000,32'h0,          0,0,3'd0,11'd0, 0,0};
    vt[1] = '{0,0,14'h0000,32'h0,          0,1,3'd3,11'd2, 0,1};
    vt[2] = '{1,1,14'h2000,32'hA0A0_0000,  1,1,3'd1,11'd7, 0,1};
    vt[3] = '{0,0,14'h0000,32'h0,          1,1,3'd1,11'd7, 0,0};
    vt[4] = '{1,1,14'h2001,32'hA0A0_0001,  0,1,3'd2,11'd9, 0,1};
    vt[5] = '{0,0,14'h0000,32'h0,          0,0,3'd0,11'd0, 0,0};
    vt[6] = '{0,0,14'h0000,32'h0,          0,1,3'd0,11'd1, 0,1};
    vt[7] = '{0,0,14'h0000,32'h0,          0,0,3'd0,11'd0, 0,0};
    vt[8] = '{1,1,14'h3005,32'h0000_DEAD,  1,0,3'd0,11'd0, 0,0};
    vt[9] = '{0,0,14'h0000,32'h0,          1,1,3'd4,11'd3, 0,1};

    @(negedge clk);
    apply_reset();

    // ---- directed table ----
    for (int i = 0; i < 10; i++) begin
      chipselect = vt[i].cs; write = vt[i].wr; address = vt[i].adr; writedata = vt[i].wd;
      vblank = vt[i].vb; ppu_req = vt[i].pr; ppu_sel = vt[i].ps; ppu_addr = vt[i].pa;
      step();
      chk($sformatf("vec%0d waitrequest", i), 32'(s_wait), 32'(vt[i].e_wait));
      chk($sformatf("vec%0d ppu_gnt", i),     32'(s_gnt),  32'(vt[i].e_gnt));
    end
    idle_inputs(); step(); step(); step();

    // ---- four OAM writes during vblank ----
    apply_reset(); clear_logs();
    vblank = 1;
    for (int i = 0; i < 4; i++) begin host_wr(14'h2000 | 14'(i), 32'h1000 + i); step(); end
    chipselect = 0; write = 0;
    for (int i = 0; i < 4; i++) step();
    chk("oam mem_we pulses", we_addr_log.size(), 4);
    chk("oam waitrequest seen", wait_seen, 0);
    if (we_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("oam order addr", 32'(we_addr_log[i]), i);
        chk("oam order data", we_data_log[i], 32'h1000 + i);
      end

    // ---- PPU read returns two cycles after grant ----
    vblank = 1; host_wr(14'h1802, 32'h00AA_BBCC); step();
    chipselect = 0; write = 0; step(); step();
    vblank = 0; ppu_req = 1; ppu_sel = 3; ppu_addr = 2; step();
    chk("read gnt N", 32'(s_gnt), 1);
    ppu_req = 0; step();
    chk("read rvalid N+1", 32'(s_rv), 0);
    step();
    chk("read rvalid N+2", 32'(s_rv), 1);
    chk("read rdata N+2", s_rdata, 32'h00AA_BBCC);

    // ---- FIFO fills while PPU holds the port ----
    apply_reset(); clear_logs();
    vblank = 0; ppu_req = 1; acc_n = 0;
    host_wr(14'(acc_n), 32'h3000 + acc_n);
    for (int k = 0; k < 20; k++) begin
      step();
      if (!s_wait) begin acc_n++; host_wr(14'(acc_n), 32'h3000 + acc_n); end
    end
    chk("fill accepted", acc_n, 8);
    chk("fill waitrequest", 32'(s_wait), 1);
    chk("fill no mem_we", we_addr_log.size(), 0);
    ppu_req = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (chipselect && !s_wait) begin
        acc_n++;
        chipselect = 0; write = 0;
      end
    end
    chk("drain accepted", acc_n, 9);
    chk("drain mem_we pulses", we_data_log.size(), 9);
    if (we_data_log.size() == 9)
      for (int i = 0; i < 9; i++) chk("drain order", we_data_log[i], 32'h3000 + i);

`ifdef PPU_ARB_STARVE_GUARD_EN
    // ---- starvation guard under a continuous PPU request ----
    apply_reset(); clear_logs();
    vblank = 0; ppu_req = 1;
    for (int k = 0; k < 208; k++) begin
      if (k < 8) host_wr(14'(k), 32'h5000 + k); else begin chipselect = 0; write = 0; end
      step();
      if (!s_gnt) denied.push_back(k);
    end
    chk("starve slots", denied.size(), 3);
    if (denied.size() == 3) begin
      chk("starve slot0", denied[0], 65);
      chk("starve slot1", denied[1], 130);
      chk("starve slot2", denied[2], 195);
    end
    ppu_req = 0;
    for (int k = 0; k < 12; k++) step();
`endif

    // ---- writes to an unmapped region saturate the drop counter ----
    apply_reset(); clear_logs();
    for (int k = 0; k < 300; k++) begin host_wr(14'h3000 | 14'(k % 2048), 32'(k)); step(); end
    chipselect = 0; write = 0; step(); step();
    chk("badsel count", 32'(bad_sel_cnt), 255);
    chk("badsel no mem_we", we_addr_log.size(), 0);

    // ---- reset with queued writes and a read in flight ----
    apply_reset();
    vblank = 0; ppu_req = 1; ppu_sel = 1; ppu_addr = 5;
    for (int k = 0; k < 5; k++) begin host_wr(14'h0800 | 14'(k), 32'h7000 + k); step(); end
    chipselect = 0; write = 0; step();
    apply_reset(); clear_logs();
    for (int k = 0; k < 8; k++) step();
    chk("postrst mem_we", we_addr_log.size(), 0);
    chk("postrst rvalid", rv_count, 0);
    chk("postrst waitrequest", 32'(s_wait), 0);

    // ---- random traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      ppu_req  = ($urandom_range(0, 9) < 6);
      ppu_sel  = 3'($urandom_range(0, 4));
      ppu_addr = 11'($urandom_range(0, 15));
      chipselect = ($urandom_range(0, 1) == 1);
      write      = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 19) < 17) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      address    = {rs, 11'($urandom_range(0, 15))};
      writedata  = $urandom;
      step();
    end
    idle_inputs();
    for (int k = 0; k < 12; k++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
